// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 16-bit shift-and-add multiplier that borrows the shared
// hack-style ALU (za/na/zb/nb/f/no) for every addition and doubling step.
// Returns the low 16 bits of a*b on product with a one-cycle done pulse.
// Optional build macro: MUL_EARLY_EXIT_EN. When it is defined, the loop stops
// once no multiplier bits remain, and a zero multiplier completes at once.
module alu_mul_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        done,
  output logic [15:0] product,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_za,
  output logic        alu_na,
  output logic        alu_zb,
  output logic        alu_nb,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  // ALU control word ordered {za, na, zb, nb, f, no}
  localparam logic [5:0] CTRL_ADD  = 6'b000010;
  localparam logic [5:0] CTRL_ZERO = 6'b101010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DBL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   result_q, result_d;

  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic [W-1:0]   alu_x_q, alu_x_d;
  logic [W-1:0]   alu_y_q, alu_y_d;
  logic [5:0]     ctrl_q, ctrl_d;

  logic           last_step;

  // State, datapath and registered output update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      alu_x_q  <= '0;
      alu_y_q  <= '0;
      ctrl_q   <= CTRL_ZERO;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      alu_x_q  <= alu_x_d;
      alu_y_q  <= alu_y_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Loop termination: fixed 16 doublings, or earlier when no multiplier bits remain
`ifdef MUL_EARLY_EXIT_EN
  assign last_step = (count_q == CW'(W - 1)) || ((mplier_q >> 1) == '0);
`else
  assign last_step = (count_q == CW'(W - 1));
`endif

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          count_d  = '0;
`ifdef MUL_EARLY_EXIT_EN
          if (b == '0) begin
            result_d = '0;
            state_d  = S_DONE;
          end else begin
            state_d = b[0] ? S_ADD : S_DBL;
          end
`else
          state_d = b[0] ? S_ADD : S_DBL;
`endif
        end
      end
      S_ADD: begin
        acc_d   = alu_out;
        state_d = S_DBL;
      end
      S_DBL: begin
        mcand_d  = alu_out;
        mplier_d = mplier_q >> 1;
        count_d  = CW'(count_q + CW'(1));
        if (last_step) begin
          result_d = acc_q;
          state_d  = S_DONE;
        end else begin
          state_d = mplier_q[1] ? S_ADD : S_DBL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, so every output comes straight off a flop
  always_comb begin
    ready_d = 1'b0;
    done_d  = 1'b0;
    alu_x_d = '0;
    alu_y_d = '0;
    ctrl_d  = CTRL_ZERO;

    unique case (state_d)
      S_IDLE: ready_d = 1'b1;
      S_ADD: begin
        alu_x_d = acc_d;
        alu_y_d = mcand_d;
        ctrl_d  = CTRL_ADD;
      end
      S_DBL: begin
        alu_x_d = mcand_d;
        alu_y_d = mcand_d;
        ctrl_d  = CTRL_ADD;
      end
      S_DONE: done_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign product = result_q;
  assign alu_x   = alu_x_q;
  assign alu_y   = alu_y_q;
  assign {alu_za, alu_na, alu_zb, alu_nb, alu_f, alu_no} = ctrl_q;

endmodule
